// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, live occupancy count,
// programmable almost_full/almost_empty thresholds and optional first-word-fall-through output.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rdata,
   output logic                         rdata_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow,
   output logic                         underflow,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
   end
   if (AE_THRESH >= AF_THRESH) begin : g_bad_order
      $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, underflow_q;
   logic             rd_accept, wr_accept;

   // Handshake: a read is taken whenever rd_en is high and the FIFO holds data; a write is
   // taken when there is room, or when full but a read frees a slot on the same edge.
   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign rd_accept    = rd_en && !empty;
   assign wr_accept    = wr_en && (!full || rd_accept);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= wr_en && !wr_accept;
         underflow_q <= rd_en && !rd_accept;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign rdata       = empty ? '0 : mem[rd_ptr_q];
      assign rdata_valid = !empty;
   end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rdata_valid_q;

      always_ff @(posedge clk or posedge res) begin
         if (res) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
         end else begin
            rdata_valid_q <= rd_accept;
            if (rd_accept) begin
               rdata_q <= mem[rd_ptr_q];
            end
         end
      end

      assign rdata       = rdata_q;
      assign rdata_valid = rdata_valid_q;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised successor to the team's asynchronous FIFO. It keeps the same wr_en/rd_en/wdata/rdata/full/empty/overflow/underflow contract and adds configurable width and depth, a live occupancy count, and programmable almost_full/almost_empty thresholds. A FWFT mode selects standard (registered-read) or first-word-fall-through output. It sits between producer and consumer blocks within one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; need not be a power of two)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  single clock; all state updates on its rising edge
res  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
wdata  in  WIDTH  write data, sampled with wr_en
rd_en  in  1  read request
rdata  out  WIDTH  read data
rdata_valid  out  1  rdata holds a newly popped word (FWFT=0); equals !empty (FWFT=1)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (res=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rdata=0, rdata_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. Memory contents are not cleared. Reset asserted mid-operation discards all stored data immediately. The first write is accepted on the first rising edge after res deasserts.
- Pointers run 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. No power-of-two modulo is used.
- Accepted write (wr_en & (!full | rd_accept)): mem[wr_ptr]<=wdata, wr_ptr advances.
- Accepted read, rd_accept (rd_en & !empty): rd_ptr advances.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- full, empty, almost_full, almost_empty derive from the registered count. They are valid in the same cycle count changes, so their latency from the accepting edge is zero.
- Full with wr_en=1 and rd_en=1: both are accepted, count stays DEPTH, overflow=0.
- Full with wr_en=1 and rd_en=0: write is dropped, memory and pointers are unchanged, overflow=1 for exactly that cycle.
- Empty with rd_en=1: read is rejected and underflow=1 for that cycle. This holds even if wr_en=1; the concurrent write is still accepted.
- FWFT=0:
  - On an accepted read, rdata<=mem[rd_ptr] at that edge, and rdata_valid=1 for the following cycle only.
  - rdata holds its last value otherwise.
  - A rejected read leaves rdata unchanged and drives rdata_valid=0.
- FWFT=1:
  - rdata = mem[rd_ptr] combinationally whenever !empty, and rdata=0 when empty.
  - rdata_valid = !empty.
  - rd_en acts as an acknowledge that pops the displayed word.
  - A word written into an empty FIFO appears on rdata the cycle after its write edge.
- overflow and underflow are registered pulses and are never sticky.
- Parameter legality (AE_THRESH < AF_THRESH, DEPTH>=2) is checked at elaboration. Violations are reported with $error.

Test Plan:
- Reset/idle (WIDTH=8, DEPTH=8, AF=6, AE=2): hold res 2 cycles, then release -> empty=1, almost_empty=1, count=0, full=0, rdata=0, no pulses.
- Fill to overflow: write 0x01..0x08, then write 0x09 -> count steps 1..8; almost_empty drops at count=3; almost_full rises at count=6; full=1 at 8; 0x09 write gives a single overflow pulse; count stays 8.
- Drain order (FWFT=0): from full, rd_en for 8 cycles, then once more -> rdata 0x01..0x08, each with rdata_valid 1 cycle after rd_en; the 9th read gives an underflow pulse; empty=1; rdata stays 0x08.
- Simultaneous read and write at full: write 0xAA with rd_en=1 -> count stays 8, overflow=0. After draining, 0xAA emerges last, and pointer wrap occurs with no data corruption.
- FWFT=1 and wrap: write 0x5A into empty -> rdata=0x5A and rdata_valid=1 the next cycle with no rd_en. Streaming 20 words at one write plus one read per cycle preserves order across wrap, with count constant at 1.
- Mid-operation reset: at count=5, pulse res asynchronously between clock edges -> all outputs go to reset values immediately; a subsequent write of 0x33 and read return 0x33.
